// File: rtl/spi_resp_pkg.sv
// rtl/spi_resp_pkg.sv - shared types and constants for the SPI register responder
// Purpose: holds the frame FSM state enum, the frame geometry and the address map constants.
// Ports: none (package).
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam int FRAME_BITS  = 16;
  localparam int ADDR_W      = 7;
  localparam int NUM_RW_REGS = 7;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = 7'd7;

  // Addresses 0..6 map to writable registers; everything from STATUS_ADDR up does not.
  function automatic logic is_rw_addr(input logic [ADDR_W-1:0] addr);
    return addr < STATUS_ADDR;
  endfunction

endpackage

// File: rtl/spi_reg_responder_sync_edge.sv
// rtl/spi_reg_responder_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
// Purpose: brings one asynchronous input into the clk domain and flags its edges.
// Ports: clk, rst (sync, active high), d (async input), q (synchronized level),
//        rise / fall (one-cycle pulses on synchronized edges).
module sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
    prev_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{IDLE_VAL}};
      prev_q  <= IDLE_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 responder exposing 7 R/W registers and a status byte
// Purpose: decodes 16-bit frames {W, addr[6:0], data[7:0]} sampled over an oversampled SPI link.
// Ports: clk, rst (sync, active high); sclk, cs_n, mosi (async SPI inputs); miso, miso_oe;
//        status_in (read at address 7); regs_out (reg0 in [7:0]); wr_strobe / wr_addr on commit.
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  status_in,
  output logic [55:0] regs_out,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_sync = ^{sclk_lvl, cs_rise};

  state_t                  state_q, state_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [7:0]              tx_q, tx_d;
  logic [7:0]              regs_q [NUM_RW_REGS];
  logic [7:0]              regs_d [NUM_RW_REGS];
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [2:0]              wr_addr_q, wr_addr_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  // Arming: after reset the cs_n synchronizer is preloaded high, so a host still holding
  // cs_n low would look like a fresh falling edge. hold_q covers the synchronizer flush,
  // and only a genuinely observed cs_n high afterwards arms the next frame start.
  logic                    armed_q, armed_d;
  logic [1:0]              hold_q, hold_d;
  logic                    mosi_lvl;
  logic [FRAME_BITS-1:0]   frame_in;

  assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];
  assign frame_in = {shift_q[FRAME_BITS-2:0], mosi_lvl};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    regs_d      = regs_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    miso_oe_d   = ~cs_lvl;
    hold_d      = (hold_q != 2'd0) ? hold_q - 2'd1 : hold_q;
    armed_d     = armed_q | ((hold_q == 2'd0) & cs_lvl);

    if (cs_lvl) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (cs_fall && armed_q) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        ADDR: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            shift_d   = frame_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              state_d = DATA;
              // Snapshot before any commit so a write frame returns the pre-write value.
              if (is_rw_addr(frame_in[ADDR_W-1:0]))
                tx_d = regs_q[frame_in[2:0]];
              else if (frame_in[ADDR_W-1:0] == STATUS_ADDR)
                tx_d = status_in;
              else
                tx_d = 8'h00;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            shift_d   = frame_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
              state_d = DONE;
              miso_d  = 1'b0;
              if (frame_in[FRAME_BITS-1] && is_rw_addr(frame_in[14:8])) begin
                regs_d[frame_in[10:8]] = frame_in[7:0];
                wr_strobe_d            = 1'b1;
                wr_addr_d              = frame_in[10:8];
              end
            end
          end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= RESET_VALUE;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      mosi_sync_q <= '0;
      armed_q     <= 1'b0;
      hold_q      <= 2'(SYNC_STAGES);
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      regs_q      <= regs_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      mosi_sync_q <= mosi_sync_d;
      armed_q     <= armed_d;
      hold_q      <= hold_d;
    end
  end

  for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_regs_out
    assign regs_out[8*i +: 8] = regs_q[i];
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, cs_n and mosi; legal values 2..3.
REQ-002 Parameter RESET_VALUE, default 8'h00: reset value of writable registers 0..6.
REQ-003 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 sclk  input  1: SPI serial clock from external host, asynchronous to clk.
REQ-006 cs_n  input  1: SPI chip select, active low, asynchronous.
REQ-007 mosi  input  1: SPI host-to-responder data, asynchronous.
REQ-008 miso  output  1: SPI responder-to-host data.
REQ-009 miso_oe  output  1: drive enable for miso; 1 = drive.
REQ-010 status_in  input  8: fabric status byte, readable at address 7.
REQ-011 regs_out  output  56: registers 0..6 concatenated, reg0 in bits 7:0.
REQ-012 wr_strobe  output  1: one-cycle pulse on each committed write.
REQ-013 wr_addr  output  3: address of the last committed write; valid while wr_strobe is high.

Function
REQ-014 SPI mode 0 only: mosi sampled on rising sclk edges; miso changes on falling sclk edges; MSB first.
REQ-015 sclk, cs_n and mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronized sclk; the host guarantees sclk period >= 8 clk periods.
REQ-016 Frame is 16 bits: bit15 = W (1 write, 0 read); bits14:8 = address (7 bits); bits7:0 = data.
REQ-017 FSM states: IDLE, ADDR, DATA, DONE; IDLE->ADDR on synchronized cs_n falling; ADDR->DATA after the 8th rising sclk; DATA->DONE after the 16th rising sclk; any state->IDLE on synchronized cs_n high.
REQ-018 Write commit: in DATA->DONE with W=1 and address 0..6, the register SHALL update and wr_strobe SHALL pulse one clk cycle after the detected 16th rising edge.
REQ-019 Writes to address 7 (read-only) or 8..127 SHALL be ignored: no register change, no wr_strobe.
REQ-020 Read snapshot: at the ADDR->DATA transition the addressed value (reg 0..6, status_in for 7, 8'h00 for 8..127) SHALL be latched into the shift register, regardless of W.
REQ-021 miso SHALL be 0 during ADDR; during DATA it SHALL present snapshot bit7 from the first falling sclk after ADDR->DATA, then bits 6..0 on subsequent falling edges.
REQ-022 miso_oe SHALL be 1 exactly while synchronized cs_n is low; miso SHALL be 0 whenever miso_oe is 0.
REQ-023 cs_n deasserted before the 16th bit (abort) SHALL return to IDLE with no write and no wr_strobe.
REQ-024 Extra sclk edges in DONE SHALL be ignored until cs_n goes high; miso SHALL hold 0 in DONE.
REQ-025 A frame whose address equals the one being written SHALL read back the pre-write value (snapshot precedes commit).

Reset
REQ-026 On rst: state IDLE, registers 0..6 = RESET_VALUE, miso = 0, miso_oe = 0, wr_strobe = 0, wr_addr = 0, bit counter = 0, synchronizer flops = idle levels (sclk 0, cs_n 1, mosi 0).
REQ-027 rst asserted mid-frame SHALL abort the frame; the frame SHALL NOT resume after rst release until cs_n has been seen high and then low again.

Structure
REQ-028 Package spi_resp_pkg SHALL hold the state enum, FRAME_BITS = 16, ADDR_W = 7, NUM_RW_REGS = 7, STATUS_ADDR = 7.
REQ-029 One sub-module, sync_edge (SYNC_STAGES synchronizer plus rise/fall pulse outputs), SHALL be instantiated for sclk and cs_n; mosi uses its synchronizer only.

Verification
REQ-030 Write frame W=1, addr 3, data 8'hA5 -> regs_out[31:24] = 8'hA5, one wr_strobe pulse with wr_addr = 3, other registers unchanged.
REQ-031 After REQ-030, read frame W=0, addr 3 -> miso bits of the data byte = 8'hA5, and miso_oe high only while cs_n is low.
REQ-032 status_in = 8'h3C, read addr 7, then write addr 7 with 8'hFF -> read returns 8'h3C; no wr_strobe; regs_out unchanged.
REQ-033 Write addr 2 with data 8'h11, cs_n raised after 12 bits -> reg2 keeps RESET_VALUE; no wr_strobe.
REQ-034 rst pulse during the DATA phase of a write to addr 1 -> reg1 = RESET_VALUE; a following full frame that writes 8'h5A succeeds.
REQ-035 Read addr 0x45 with 20 sclk pulses -> data byte = 8'h00; miso = 0 for bits 17..20; no wr_strobe.
